xbar_cmd: RTL and testbench

//  Command sequencer upstream of the crossbar switch.

---
 rtl/xbar_cmd_pkg.sv | 35 +++
 rtl/xbar_cmd_timer.sv | 33 +++
 rtl/xbar_cmd.sv | 223 ++++++++++++++++++++++
 tb/tb_xbar_cmd.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xbar_cmd_pkg.sv
// Shared definitions for the crossbar command sequencer.
//   - Opcode bytes accepted from the UART receiver.
//   - Status bytes returned to the UART transmitter.
//   - Sequencer state encoding and a helper that tells which states are busy.
package xbar_cmd_pkg;

    // Frame opcodes
    localparam logic [7:0] OP_LINK    = 8'h4C;  // 'L' f t
    localparam logic [7:0] OP_CLEAR   = 8'h43;  // 'C' t
    localparam logic [7:0] OP_ZAP     = 8'h5A;  // 'Z'

    // Status replies
    localparam logic [7:0] ST_OK      = 8'h4B;  // 'K'
    localparam logic [7:0] ST_BAD     = 8'h3F;  // '?'
    localparam logic [7:0] ST_TIMEOUT = 8'h54;  // 'T'
    localparam logic [7:0] ST_OVERRUN = 8'h21;  // '!'

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARG1,
        S_ARG2,
        S_SETUP,
        S_PUT_H,
        S_PUT_L,
        S_ZAP,
        S_REPLY
    } state_t;

    // Only the frame-collecting states accept bytes; everywhere else a
    // received byte is an overrun.
    function automatic logic is_busy(input state_t s);
        return !(s == S_IDLE || s == S_ARG1 || s == S_ARG2);
    endfunction

endpackage

// File: rtl/xbar_cmd_timer.sv
// Loadable down-counter with a zero flag.
// One instance is shared by the put-high, put-low and inter-byte timeout
// intervals, since at most one of them is running at any time.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   load         load 'value' this cycle (takes priority over counting)
//   value        reload value; the interval lasts value+1 cycles
//   zero         high while the count is zero (counter parks at zero)
module xbar_cmd_timer #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] value,
    output logic          zero
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/xbar_cmd.sv
// Command sequencer in front of the crossbar switch.
// Parses 'L' f t / 'C' t / 'Z' frames from the UART receiver, drives the
// crossbar from/to/put/xb_reset pins with setup, strobe and hold timing, and
// returns one status byte per command.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   rx_valid     rx_data valid for exactly this cycle (no backpressure)
//   rx_data      received byte
//   tx_ready     UART tx can accept a byte
//   tx_valid     status byte offered
//   tx_data      status byte
//   from, to     crossbar source / destination column (from = all-ones clears)
//   put          crossbar strobe: latch on rise, apply on fall
//   xb_reset     one-cycle crossbar reset pulse
//   busy         high outside IDLE/ARG1/ARG2
//   dbg_state    current sequencer state
//
// Handshake: tx_valid/tx_ready is a strict valid/ready pair. Once tx_valid
// rises, tx_data is held stable and tx_valid stays high until the cycle in
// which tx_ready is also high; the byte transfers on that clock edge.
module xbar_cmd
    import xbar_cmd_pkg::*;
#(
    parameter int W       = 8,
    parameter int IN      = 8,
    parameter int OUT     = 8,
    parameter int PUT_HI  = 2,
    parameter int PUT_LO  = 2,
    parameter int TIMEOUT = 1000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    input  logic         tx_ready,
    output logic         tx_valid,
    output logic [7:0]   tx_data,
    output logic [W-1:0] from,
    output logic [W-1:0] to,
    output logic         put,
    output logic         xb_reset,
    output logic         busy,
    output state_t       dbg_state
);

    localparam int MAXV_A = (PUT_HI > PUT_LO) ? PUT_HI : PUT_LO;
    localparam int MAXV   = (TIMEOUT > MAXV_A) ? TIMEOUT : MAXV_A;
    localparam int CW     = $clog2(MAXV + 1);

    state_t        state;
    logic [7:0]    op;
    logic          overrun;
    logic          overrun_hit;
    logic          to_ok;
    logic          from_ok;
    logic [7:0]    rep_ok;
    logic [7:0]    rep_bad;
    logic [7:0]    rep_tmo;
    logic          tmr_load;
    logic [CW-1:0] tmr_value;
    logic          tmr_zero;

    assign dbg_state   = state;
    assign overrun_hit = rx_valid && is_busy(state);

    // Address checks are unsigned on the raw values; a clear carries
    // from = all-ones legitimately, so only a link checks its source.
    assign to_ok   = ({24'd0, rx_data} < 32'(OUT));
    assign from_ok = (op == OP_CLEAR) || (32'(from) < 32'(IN));

    // A byte lost while busy replaces whatever status this command earns.
    // The byte arriving on the very edge that enters REPLY must count too.
    assign rep_ok  = (overrun || overrun_hit) ? ST_OVERRUN : ST_OK;
    assign rep_bad = (overrun || overrun_hit) ? ST_OVERRUN : ST_BAD;
    assign rep_tmo = (overrun || overrun_hit) ? ST_OVERRUN : ST_TIMEOUT;

    // Timer reloads: inter-byte timeout on every accepted frame byte,
    // strobe width on SETUP->PUT_H, hold time on PUT_H->PUT_L.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = '0;
        case (state)
            S_IDLE: begin
                if (rx_valid && (rx_data == OP_LINK || rx_data == OP_CLEAR)) begin
                    tmr_load  = 1'b1;
                    tmr_value = CW'(TIMEOUT - 1);
                end
            end
            S_ARG1: begin
                if (rx_valid) begin
                    tmr_load  = 1'b1;
                    tmr_value = CW'(TIMEOUT - 1);
                end
            end
            S_SETUP: begin
                tmr_load  = 1'b1;
                tmr_value = CW'(PUT_HI - 1);
            end
            S_PUT_H: begin
                if (tmr_zero) begin
                    tmr_load  = 1'b1;
                    tmr_value = CW'(PUT_LO - 1);
                end
            end
            default: ;
        endcase
    end

    xbar_cmd_timer #(.CW(CW)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            op       <= 8'h00;
            from     <= '0;
            to       <= '0;
            put      <= 1'b0;
            xb_reset <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            // Sticky until the reply goes out; a new loss on that same edge wins.
            overrun <= overrun_hit || (overrun && !(tx_valid && tx_ready));

            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        op <= rx_data;
                        case (rx_data)
                            OP_LINK: state <= S_ARG1;
                            OP_CLEAR: begin
                                from  <= '1;
                                state <= S_ARG2;
                            end
                            OP_ZAP: begin
                                xb_reset <= 1'b1;
                                busy     <= 1'b1;
                                state    <= S_ZAP;
                            end
                            default: begin
                                tx_valid <= 1'b1;
                                tx_data  <= rep_bad;
                                busy     <= 1'b1;
                                state    <= S_REPLY;
                            end
                        endcase
                    end
                end
                S_ARG1: begin
                    if (rx_valid) begin
                        from  <= W'(rx_data);
                        state <= S_ARG2;
                    end else if (tmr_zero) begin
                        tx_valid <= 1'b1;
                        tx_data  <= rep_tmo;
                        busy     <= 1'b1;
                        state    <= S_REPLY;
                    end
                end
                S_ARG2: begin
                    if (rx_valid) begin
                        to   <= W'(rx_data);
                        busy <= 1'b1;
                        if (to_ok && from_ok) begin
                            state <= S_SETUP;
                        end else begin
                            tx_valid <= 1'b1;
                            tx_data  <= rep_bad;
                            state    <= S_REPLY;
                        end
                    end else if (tmr_zero) begin
                        tx_valid <= 1'b1;
                        tx_data  <= rep_tmo;
                        busy     <= 1'b1;
                        state    <= S_REPLY;
                    end
                end
                S_SETUP: begin
                    put   <= 1'b1;
                    state <= S_PUT_H;
                end
                S_PUT_H: begin
                    if (tmr_zero) begin
                        put   <= 1'b0;
                        state <= S_PUT_L;
                    end
                end
                S_PUT_L: begin
                    if (tmr_zero) begin
                        tx_valid <= 1'b1;
                        tx_data  <= rep_ok;
                        state    <= S_REPLY;
                    end
                end
                S_ZAP: begin
                    xb_reset <= 1'b0;
                    tx_valid <= 1'b1;
                    tx_data  <= rep_ok;
                    state    <= S_REPLY;
                end
                S_REPLY: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xbar_cmd.sv
// Bench for xbar_cmd: drives UART bytes, keeps a model crossbar fed from the
// put/xb_reset pins, and checks status bytes against an expected queue.
module tb_xbar_cmd;
    import xbar_cmd_pkg::*;

    localparam int W   = 8;
    localparam int OUT = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         rx_valid;
    logic [7:0]   rx_data;
    logic         tx_ready;
    logic         tx_valid;
    logic [7:0]   tx_data;
    logic [W-1:0] from;
    logic [W-1:0] to;
    logic         put;
    logic         xb_reset;
    logic         busy;
    state_t       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];

    // Model crossbar state
    int           put_rises  = 0;
    int           zap_cycles = 0;
    logic         prev_put   = 1'b0;
    logic [W-1:0] lat_from   = '0;
    logic [W-1:0] lat_to     = '0;
    logic         xb_val[OUT];
    logic [W-1:0] xb_src[OUT];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    xbar_cmd dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .from      (from),
        .to        (to),
        .put       (put),
        .xb_reset  (xb_reset),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- monitor: model crossbar + scoreboard ----------------
    initial begin
        for (int i = 0; i < OUT; i++) begin
            xb_val[i] = 1'b0;
            xb_src[i] = '0;
        end
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_put = 1'b0;
                for (int i = 0; i < OUT; i++) xb_val[i] = 1'b0;
            end else begin
                n_checks++;
                if (put && xb_reset) begin
                    n_fail++;
                    $display("FAIL put_and_xb_reset: put=%0b xb_reset=%0b required not both high", put, xb_reset);
                end
                if (put && prev_put && (from !== lat_from || to !== lat_to)) begin
                    n_fail++;
                    $display("FAIL addr_hold_during_put: from=%0h to=%0h required %0h %0h", from, to, lat_from, lat_to);
                end
                if (xb_reset) begin
                    zap_cycles++;
                    for (int i = 0; i < OUT; i++) xb_val[i] = 1'b0;
                end
                if (put && !prev_put) begin
                    put_rises++;
                    lat_from = from;
                    lat_to   = to;
                end
                if (!put && prev_put && (32'(lat_to) < OUT)) begin
                    if (lat_from == '1) begin
                        xb_val[lat_to] = 1'b0;
                    end else begin
                        xb_val[lat_to] = 1'b1;
                        xb_src[lat_to] = lat_from;
                    end
                end
                prev_put = put;
                if (tx_valid && tx_ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL reply_unexpected: got %02h required no reply", tx_data);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (tx_data !== e) begin
                            n_fail++;
                            $display("FAIL reply_byte: got %02h required %02h", tx_data, e);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called #1 after a rising edge; presents one byte for exactly one cycle.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Waits (bounded) for every expected reply to be transferred.
    task automatic wait_replies(input int budget);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reply_wait: %0d replies outstanding required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        @(negedge clk);
        n_checks++; if (from !== 8'h00)     begin n_fail++; $display("FAIL reset_from: got %0h required 0", from); end
        n_checks++; if (to !== 8'h00)       begin n_fail++; $display("FAIL reset_to: got %0h required 0", to); end
        n_checks++; if (put !== 1'b0)       begin n_fail++; $display("FAIL reset_put: got %0b required 0", put); end
        n_checks++; if (xb_reset !== 1'b0)  begin n_fail++; $display("FAIL reset_xb_reset: got %0b required 0", xb_reset); end
        n_checks++; if (tx_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_tx_valid: got %0b required 0", tx_valid); end
        n_checks++; if (tx_data !== 8'h00)  begin n_fail++; $display("FAIL reset_tx_data: got %0h required 0", tx_data); end
        n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %0b required 0", busy); end
        n_checks++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d required IDLE", dbg_state); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: busy=%0b tx_valid=%0b required 0 0", busy, tx_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_link;
        logic [5:0] ps;
        exp_q.push_back(8'h4B);
        send_byte(8'h4C);
        send_byte(8'd3);
        send_byte(8'd5);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ps[i] = put;
            if (i == 0) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL link_busy_setup: got %0b required 1", busy); end
            end
            if (i == 3) begin
                n_checks++; if (from !== 8'd3 || to !== 8'd5) begin n_fail++; $display("FAIL link_addr_hold: from=%0d to=%0d required 3 5", from, to); end
            end
        end
        n_checks++; if (ps !== 6'b000110) begin n_fail++; $display("FAIL link_put_timing: got %06b required 000110", ps); end
        n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h4B) begin n_fail++; $display("FAIL link_reply_latency: valid=%0b data=%02h required 1 4b", tx_valid, tx_data); end
        wait_replies(50);
        n_checks++; if (xb_val[5] !== 1'b1 || xb_src[5] !== 8'd3) begin n_fail++; $display("FAIL link_xbar_out5: val=%0b src=%0d required 1 3", xb_val[5], xb_src[5]); end
    endtask

    task automatic test_clear;
        int r0;
        r0 = put_rises;
        exp_q.push_back(8'h4B);
        send_byte(8'h43);
        send_byte(8'd5);
        wait_replies(50);
        n_checks++; if (from !== 8'hFF) begin n_fail++; $display("FAIL clear_from: got %02h required ff", from); end
        n_checks++; if (put_rises - r0 !== 1) begin n_fail++; $display("FAIL clear_put_pulses: got %0d required 1", put_rises - r0); end
        n_checks++; if (xb_val[5] !== 1'b0) begin n_fail++; $display("FAIL clear_xbar_out5: got %0b required 0", xb_val[5]); end
    endtask

    task automatic test_reject;
        int r0;
        r0 = put_rises;
        exp_q.push_back(8'h3F);
        send_byte(8'h4C); send_byte(8'd8); send_byte(8'd1);
        wait_replies(50);
        n_checks++; if (from !== 8'd8 || to !== 8'd1) begin n_fail++; $display("FAIL reject_addr_update: from=%0d to=%0d required 8 1", from, to); end
        exp_q.push_back(8'h3F);
        send_byte(8'h00);
        wait_replies(50);
        exp_q.push_back(8'h3F);
        send_byte(8'h4C); send_byte(8'hFF); send_byte(8'd0);
        wait_replies(50);
        exp_q.push_back(8'h3F);
        send_byte(8'h43); send_byte(8'd8);
        wait_replies(50);
        n_checks++; if (put_rises !== r0) begin n_fail++; $display("FAIL reject_no_put: got %0d rises required 0", put_rises - r0); end
        exp_q.push_back(8'h4B);
        send_byte(8'h4C); send_byte(8'd7); send_byte(8'd7);
        wait_replies(50);
        n_checks++; if (xb_val[7] !== 1'b1 || xb_src[7] !== 8'd7) begin n_fail++; $display("FAIL edge_link_7_7: val=%0b src=%0d required 1 7", xb_val[7], xb_src[7]); end
    endtask

    task automatic test_timeout;
        int r0;
        int z0;
        int n;
        r0 = put_rises;
        exp_q.push_back(8'h54);
        send_byte(8'h4C);
        send_byte(8'd2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_valid && n < 1200);
        n_checks++; if (n !== 1001) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles required 1001", n); end
        wait_replies(20);
        n_checks++; if (put_rises !== r0) begin n_fail++; $display("FAIL timeout_no_put: got %0d rises required 0", put_rises - r0); end
        z0 = zap_cycles;
        exp_q.push_back(8'h4B);
        send_byte(8'h5A);
        @(negedge clk);
        n_checks++; if (xb_reset !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL zap_pulse: xb_reset=%0b busy=%0b required 1 1", xb_reset, busy); end
        @(negedge clk);
        n_checks++; if (xb_reset !== 1'b0 || tx_valid !== 1'b1) begin n_fail++; $display("FAIL zap_end: xb_reset=%0b tx_valid=%0b required 0 1", xb_reset, tx_valid); end
        wait_replies(20);
        n_checks++; if (zap_cycles - z0 !== 1) begin n_fail++; $display("FAIL zap_width: got %0d cycles required 1", zap_cycles - z0); end
    endtask

    task automatic test_overrun;
        int z0;
        int n;
        z0 = zap_cycles;
        tx_ready = 1'b0;
        exp_q.push_back(8'h21);
        send_byte(8'h4C); send_byte(8'd1); send_byte(8'd2);
        @(posedge clk);
        #1;
        send_byte(8'h5A);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_valid && n < 20);
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_reply_offer: got %0b required 1", tx_valid); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h21) begin
                n_fail++;
                $display("FAIL overrun_hold_%0d: valid=%0b data=%02h required 1 21", i, tx_valid, tx_data);
            end
        end
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        wait_replies(20);
        n_checks++; if (zap_cycles !== z0) begin n_fail++; $display("FAIL overrun_byte_ignored: got %0d zap cycles required 0", zap_cycles - z0); end
        n_checks++; if (xb_val[2] !== 1'b1 || xb_src[2] !== 8'd1) begin n_fail++; $display("FAIL overrun_link_done: val=%0b src=%0d required 1 1", xb_val[2], xb_src[2]); end
        exp_q.push_back(8'h4B);
        send_byte(8'h43); send_byte(8'd2);
        wait_replies(50);
        n_checks++; if (xb_val[2] !== 1'b0) begin n_fail++; $display("FAIL after_overrun_clear: got %0b required 0", xb_val[2]); end
    endtask

    task automatic test_reset_mid;
        send_byte(8'h4C); send_byte(8'd4); send_byte(8'd6);
        @(negedge clk);
        @(posedge clk);
        #1;
        n_checks++; if (put !== 1'b1) begin n_fail++; $display("FAIL midreset_put_before: got %0b required 1", put); end
        reset = 1'b1;
        #1;
        n_checks++; if (put !== 1'b0) begin n_fail++; $display("FAIL midreset_put: got %0b required 0", put); end
        n_checks++; if (tx_valid !== 1'b0 || xb_reset !== 1'b0) begin n_fail++; $display("FAIL midreset_tx_xb: tx_valid=%0b xb_reset=%0b required 0 0", tx_valid, xb_reset); end
        n_checks++; if (busy !== 1'b0 || dbg_state !== S_IDLE) begin n_fail++; $display("FAIL midreset_state: busy=%0b state=%0d required 0 IDLE", busy, dbg_state); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_q.push_back(8'h4B);
        send_byte(8'h4C); send_byte(8'd0); send_byte(8'd0);
        wait_replies(50);
        n_checks++; if (xb_val[0] !== 1'b1 || xb_src[0] !== 8'd0) begin n_fail++; $display("FAIL midreset_relink: val=%0b src=%0d required 1 0", xb_val[0], xb_src[0]); end
        n_checks++; if (xb_val[6] !== 1'b0) begin n_fail++; $display("FAIL midreset_abort_not_applied: got %0b required 0", xb_val[6]); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_link();
        test_clear();
        test_reject();
        test_timeout();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
